prga_enc: RTL and testbench

- ARC4 keystream encryptor: the encode-side counterpart of the existing prga decryptor.
- Uses the S-box that ksa has already permuted, and modifies S in place.
- Reads a length-prefixed plaintext memory (pt[0]=L, pt[1..L]=bytes) and writes a length-prefixed ciphertext memory (ct[0]=L, ct[k]=pt[k]^pad_k).
- Used for on-chip generation of test ciphertext and for encrypt/decrypt round-trip checks.

---
 rtl/prga_enc.sv | 164 ++++++++++++++++
 tb/tb_prga_enc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prga_enc.sv
// ARC4 keystream encryptor: walks a length-prefixed plaintext, advances the
// PRGA on the shared S-box (swapping in place) and writes pt^pad to ct.
module prga_enc (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] s_addr,
   input  logic [7:0] s_rddata,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   output logic [7:0] pt_addr,
   input  logic [7:0] pt_rddata,
   output logic [7:0] ct_addr,
   output logic [7:0] ct_wrdata,
   output logic       ct_wren
);

   typedef enum logic [3:0] {
      IDLE, RD_LEN, WAIT_LEN, WR_LEN,
      RD_SI, WAIT_SI, RD_SJ, WAIT_SJ,
      WR_SI, WR_SJ, RD_PAD, WAIT_PAD, WR_CT, DONE
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] i_reg, i_next, j_reg, j_next, k_reg, k_next;
   logic [7:0] len_reg, len_next, si_reg, si_next, sj_reg, sj_next;

   logic       rdy_reg, rdy_next;
   logic [7:0] s_addr_reg, s_addr_next, s_wrdata_reg, s_wrdata_next;
   logic       s_wren_reg, s_wren_next;
   logic [7:0] pt_addr_reg, pt_addr_next;
   logic [7:0] ct_addr_reg, ct_addr_next, ct_wrdata_reg, ct_wrdata_next;
   logic       ct_wren_reg, ct_wren_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         i_reg         <= '0;
         j_reg         <= '0;
         k_reg         <= '0;
         len_reg       <= '0;
         si_reg        <= '0;
         sj_reg        <= '0;
         rdy_reg       <= 1'b0;
         s_addr_reg    <= '0;
         s_wrdata_reg  <= '0;
         s_wren_reg    <= 1'b0;
         pt_addr_reg   <= '0;
         ct_addr_reg   <= '0;
         ct_wrdata_reg <= '0;
         ct_wren_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         i_reg         <= i_next;
         j_reg         <= j_next;
         k_reg         <= k_next;
         len_reg       <= len_next;
         si_reg        <= si_next;
         sj_reg        <= sj_next;
         rdy_reg       <= rdy_next;
         s_addr_reg    <= s_addr_next;
         s_wrdata_reg  <= s_wrdata_next;
         s_wren_reg    <= s_wren_next;
         pt_addr_reg   <= pt_addr_next;
         ct_addr_reg   <= ct_addr_next;
         ct_wrdata_reg <= ct_wrdata_next;
         ct_wren_reg   <= ct_wren_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (en && rdy_reg) state_next = RD_LEN;
         RD_LEN:   state_next = WAIT_LEN;
         WAIT_LEN: state_next = WR_LEN;
         WR_LEN:   state_next = (len_reg == 8'd0) ? DONE : RD_SI;
         RD_SI:    state_next = WAIT_SI;
         WAIT_SI:  state_next = RD_SJ;
         RD_SJ:    state_next = WAIT_SJ;
         WAIT_SJ:  state_next = WR_SI;
         WR_SI:    state_next = WR_SJ;
         WR_SJ:    state_next = RD_PAD;
         RD_PAD:   state_next = WAIT_PAD;
         WAIT_PAD: state_next = WR_CT;
         WR_CT:    state_next = (k_reg == len_reg) ? DONE : RD_SI;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Outputs are computed for the state being entered so every port is a flop.
   always_comb begin
      i_next         = i_reg;
      j_next         = j_reg;
      k_next         = k_reg;
      len_next       = len_reg;
      si_next        = si_reg;
      sj_next        = sj_reg;
      rdy_next       = (state_next == IDLE);
      s_addr_next    = '0;
      s_wrdata_next  = '0;
      s_wren_next    = 1'b0;
      pt_addr_next   = '0;
      ct_addr_next   = '0;
      ct_wrdata_next = '0;
      ct_wren_next   = 1'b0;

      if (state_reg == IDLE && state_next == RD_LEN) begin
         i_next = '0;
         j_next = '0;
         k_next = 8'd1;
      end
      if (state_reg == WAIT_LEN) len_next = pt_rddata;
      if (state_reg == WAIT_SI) begin
         si_next = s_rddata;
         j_next  = j_reg + s_rddata;
      end
      if (state_reg == WAIT_SJ) sj_next = s_rddata;
      if (state_reg == WR_CT && state_next == RD_SI) k_next = k_reg + 8'd1;
      if (state_next == RD_SI) i_next = i_reg + 8'd1;

      case (state_next)
         WR_LEN: begin
            ct_wrdata_next = len_next;
            ct_wren_next   = 1'b1;
         end
         RD_SI:  s_addr_next = i_next;
         RD_SJ:  s_addr_next = j_next;
         WR_SI: begin
            s_addr_next   = i_reg;
            s_wrdata_next = sj_next;
            s_wren_next   = 1'b1;
         end
         WR_SJ: begin
            s_addr_next   = j_reg;
            s_wrdata_next = si_reg;
            s_wren_next   = 1'b1;
         end
         // Issued after both swap writes, so the pad sees the swapped S.
         RD_PAD: begin
            s_addr_next  = si_reg + sj_reg;
            pt_addr_next = k_reg;
         end
         WR_CT: begin
            ct_addr_next   = k_reg;
            ct_wrdata_next = s_rddata ^ pt_rddata;
            ct_wren_next   = 1'b1;
         end
         default: ;
      endcase
   end

   assign rdy       = rdy_reg;
   assign s_addr    = s_addr_reg;
   assign s_wrdata  = s_wrdata_reg;
   assign s_wren    = s_wren_reg;
   assign pt_addr   = pt_addr_reg;
   assign ct_addr   = ct_addr_reg;
   assign ct_wrdata = ct_wrdata_reg;
   assign ct_wren   = ct_wren_reg;

endmodule

// File: tb/tb_prga_enc.sv
// Bench for prga_enc: behavioural S/pt/ct memories, an ARC4 reference model
// feeding a ct-write scoreboard, plus latency, reset and abort checks.
module tb_prga_enc;

   logic       clk = 1'b0;
   logic       rst_n, en, rdy;
   logic [7:0] s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata;
   logic [7:0] ct_addr, ct_wrdata;
   logic       s_wren, ct_wren;

   logic [7:0]  s_mem[256], pt_mem[256], ct_mem[256];
   logic [7:0]  model_s[256], s_orig[256], pt_orig[256];
   logic [15:0] exp_q[$];
   logic [15:0] mon_e;
   int vectors = 0, miscompares = 0, ct_writes = 0, s_writes = 0;

   prga_enc dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
      .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
      .pt_addr(pt_addr), .pt_rddata(pt_rddata),
      .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      s_rddata  <= s_mem[s_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (s_wren)  s_mem[s_addr]   <= s_wrdata;
      if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ct_wren) begin
         ct_writes++;
         $display("ct write [%0d] = %02h", ct_addr, ct_wrdata);
         if (exp_q.size() == 0) begin
            check("ct_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("ct_addr", {24'd0, ct_addr}, {24'd0, mon_e[15:8]});
            check("ct_data", {24'd0, ct_wrdata}, {24'd0, mon_e[7:0]});
         end
      end
      if (s_wren) s_writes++;
   end

   // Reference ARC4 PRGA on model_s; pushes the expected ct write sequence.
   task automatic model_run(input int len);
      int mi = 0, mj = 0, si, sj, kk;
      logic [7:0] pad;
      exp_q.push_back({8'd0, len[7:0]});
      for (int k = 1; k <= len; k++) begin
         mi = (mi + 1) % 256;
         si = int'(model_s[mi]);
         mj = (mj + si) % 256;
         sj = int'(model_s[mj]);
         model_s[mi] = sj[7:0];
         model_s[mj] = si[7:0];
         pad = model_s[(si + sj) % 256];
         kk = k;
         exp_q.push_back({kk[7:0], pad ^ pt_mem[k]});
      end
   endtask

   task automatic run_enc(input int len, input bit busy_pulse);
      int cnt = 0;
      @(negedge clk);
      check("rdy_before", {31'd0, rdy}, 32'd1);
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      check("rdy_drop", {31'd0, rdy}, 32'd0);
      while (cnt < 3000) begin
         @(posedge clk);
         #1;
         cnt++;
         en = busy_pulse && (cnt == 5 || cnt == 6);
         if (rdy) break;
      end
      en = 1'b0;
      check("latency", cnt, 4 + 9 * len);
      check("q_empty", exp_q.size(), 32'd0);
   endtask

   task automatic load_identity();
      for (int a = 0; a < 256; a++) begin
         s_mem[a]   = a[7:0];
         model_s[a] = a[7:0];
      end
   endtask

   task automatic compare_s();
      for (int a = 0; a < 256; a++) check("s_mem", {24'd0, s_mem[a]}, {24'd0, model_s[a]});
   endtask

   initial begin
      string msg;
      logic [7:0] t;
      int cw0, sw0, cnt, b;
      msg = "Hello round trip";
      for (int a = 0; a < 256; a++) begin
         pt_mem[a] = '0;
         ct_mem[a] = '0;
      end
      load_identity();

      rst_n = 1'b0;
      en    = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rst_rdy", {31'd0, rdy}, 32'd0);
      check("rst_s_wren", {31'd0, s_wren}, 32'd0);
      check("rst_ct_wren", {31'd0, ct_wren}, 32'd0);
      check("rst_addrs", {8'd0, s_addr, pt_addr, ct_addr}, 32'd0);
      check("rst_wrdata", {16'd0, s_wrdata, ct_wrdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rdy_after_rst", {31'd0, rdy}, 32'd1);
      en = 1'b0;

      // Single byte on identity S
      pt_mem[0] = 8'd1; pt_mem[1] = 8'h00;
      sw0 = s_writes;
      model_run(1);
      run_enc(1, 1'b0);
      check("t1_ct0", {24'd0, ct_mem[0]}, 32'h01);
      check("t1_ct1", {24'd0, ct_mem[1]}, 32'h02);
      check("t1_swrites", s_writes - sw0, 32'd2);
      compare_s();

      // Two bytes on identity S
      load_identity();
      pt_mem[0] = 8'd2; pt_mem[1] = 8'h00; pt_mem[2] = 8'h00;
      model_run(2);
      run_enc(2, 1'b0);
      check("t2_ct1", {24'd0, ct_mem[1]}, 32'h02);
      check("t2_ct2", {24'd0, ct_mem[2]}, 32'h05);
      check("t2_s2", {24'd0, s_mem[2]}, 32'h03);
      check("t2_s3", {24'd0, s_mem[3]}, 32'h02);
      compare_s();

      // Empty message
      pt_mem[0] = 8'd0;
      cw0 = ct_writes; sw0 = s_writes;
      model_run(0);
      run_enc(0, 1'b0);
      check("t3_ctwrites", ct_writes - cw0, 32'd1);
      check("t3_swrites", s_writes - sw0, 32'd0);

      // Round trip on a shuffled S, with en pulsed mid-run
      for (int a = 255; a > 0; a--) begin
         b = $urandom_range(a, 0);
         t = s_mem[a]; s_mem[a] = s_mem[b]; s_mem[b] = t;
      end
      for (int a = 0; a < 256; a++) begin
         model_s[a] = s_mem[a];
         s_orig[a]  = s_mem[a];
      end
      pt_mem[0] = 8'd16;
      for (int n = 0; n < 16; n++) pt_mem[n + 1] = msg[n];
      for (int a = 0; a <= 16; a++) pt_orig[a] = pt_mem[a];
      cw0 = ct_writes;
      model_run(16);
      run_enc(16, 1'b1);
      check("t4_busy_ctwrites", ct_writes - cw0, 32'd17);
      for (int a = 0; a < 256; a++) begin
         s_mem[a]   = s_orig[a];
         model_s[a] = s_orig[a];
      end
      for (int a = 0; a <= 16; a++) pt_mem[a] = ct_mem[a];
      model_run(16);
      run_enc(16, 1'b0);
      for (int a = 0; a <= 16; a++) check("t4_roundtrip", {24'd0, ct_mem[a]}, {24'd0, pt_orig[a]});

      // Maximum length, S carried over from the previous run
      pt_mem[0] = 8'd255;
      for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom_range(255, 0));
      model_run(255);
      run_enc(255, 1'b0);
      compare_s();

      // Abort during the first S write
      pt_mem[0] = 8'd3;
      exp_q.push_back({8'd0, 8'd3});
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      cnt = 0;
      while (cnt < 50) begin
         @(posedge clk);
         #1;
         cnt++;
         if (s_wren) break;
      end
      check("abort_wr_si_seen", {31'd0, s_wren}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_s_wren", {31'd0, s_wren}, 32'd0);
      check("abort_rdy", {31'd0, rdy}, 32'd0);
      check("abort_ct_wren", {31'd0, ct_wren}, 32'd0);
      cw0 = ct_writes; sw0 = s_writes;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort_rdy_after", {31'd0, rdy}, 32'd1);
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_ct", ct_writes - cw0, 32'd0);
      check("abort_no_s", s_writes - sw0, 32'd0);
      check("abort_q", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
